// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter: round-robin sharing of one pipelined sqrt core between NREQ requesters,
// with an in-flight tag FIFO that routes each in-order core result back to its issuer.
module sqrt_share_arbiter #(
  parameter int NREQ      = 2,
  parameter int PRECISION = 32,
  parameter int OUT_W     = 24,
  parameter int MAX_INFLT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*PRECISION-1:0]     req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic                          sqrt_in_valid,
  output logic [PRECISION-1:0]          sqrt_in_data,
  input  logic                          sqrt_out_valid,
  input  logic [OUT_W-1:0]              sqrt_out_data,
  output logic [NREQ-1:0]               resp_valid,
  output logic [OUT_W-1:0]              resp_data,
  input  logic                          flush,
  output logic                          drained,
  output logic [$clog2(MAX_INFLT):0]    inflight,
  output logic                          err_underflow
);
  localparam int TW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(MAX_INFLT);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [TW-1:0] rr, g;
  logic [TW-1:0] fifo [MAX_INFLT];
  logic [AW-1:0] wp, rp;
  logic found, grant_ok, xfer, pop;
  int idx;
  always_comb begin
    g = rr;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      idx = idx >= NREQ ? idx - NREQ : idx;
      if (!found && req_valid[TW'(idx)]) begin
        g = TW'(idx);
        found = 1'b1;
      end
    end
  end
  // inflight never exceeds MAX_INFLT (a power of 2), so its top bit alone means full
  assign grant_ok  = rst_n && state == RUN && !inflight[AW];
  assign req_ready = (grant_ok && found) ? NREQ'(1) << g : '0;
  assign xfer      = |(req_valid & req_ready);
  assign pop       = sqrt_out_valid && inflight != '0;
  always_comb begin
    state_nx = state;
    drained  = 1'b0;
    if (state == RUN) state_nx = flush ? DRAIN : RUN;
    else if (inflight == '0) begin
      state_nx = RUN;
      drained  = 1'b1;
    end
  end
  always_ff @(posedge clk) if (xfer) fifo[wp] <= g;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      rr            <= '0;
      wp            <= '0;
      rp            <= '0;
      inflight      <= '0;
      sqrt_in_valid <= 1'b0;
      sqrt_in_data  <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nx;
      sqrt_in_valid <= xfer;
      inflight      <= inflight + (AW+1)'(xfer) - (AW+1)'(pop);
      resp_valid    <= pop ? NREQ'(1) << fifo[rp] : '0;
      err_underflow <= err_underflow | (sqrt_out_valid && !pop);
      if (xfer) begin
        rr           <= g == TW'(NREQ-1) ? '0 : g + 1'b1;
        sqrt_in_data <= req_data[g*PRECISION +: PRECISION];
        wp           <= wp + 1'b1;
      end
      if (pop) begin
        resp_data <= sqrt_out_data;
        rp        <= rp + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// tb_sqrt_share_arbiter: directed table of per-cycle vectors plus hand sequences for
// stall/full, reset, flush/drain and underflow; the bench plays the sqrt core.
module tb_sqrt_share_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, resp_valid;
  logic [63:0] req_data = {32'd100, 32'd25};
  logic sqrt_in_valid, sqrt_out_valid = 1'b0, flush = 1'b0, drained, err_underflow;
  logic [31:0] sqrt_in_data;
  logic [23:0] sqrt_out_data = '0, resp_data;
  logic [3:0] inflight;
  int n_chk = 0, n_fail = 0, grants;
  typedef struct {
    logic [1:0] rv; logic ov; logic [23:0] od;
    logic [1:0] e_rdy; logic e_iv; logic [31:0] e_id;
    logic [1:0] e_rv; logic [23:0] e_rd; logic [3:0] e_inf;
  } vec_t;
  vec_t tbl [16];
  sqrt_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sqrt_in_valid(sqrt_in_valid), .sqrt_in_data(sqrt_in_data),
    .sqrt_out_valid(sqrt_out_valid), .sqrt_out_data(sqrt_out_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush), .drained(drained),
    .inflight(inflight), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    // T2 from reset (grants 0,1,0,1; results 3..6), then T1 (single requester, 25 -> 5)
    tbl[0]  = '{2'b11, 0, 0, 2'b01, 0, 0,   2'b00, 0, 0};
    tbl[1]  = '{2'b11, 0, 0, 2'b10, 1, 25,  2'b00, 0, 1};
    tbl[2]  = '{2'b11, 0, 0, 2'b01, 1, 100, 2'b00, 0, 2};
    tbl[3]  = '{2'b11, 0, 0, 2'b10, 1, 25,  2'b00, 0, 3};
    tbl[4]  = '{2'b00, 1, 3, 2'b00, 1, 100, 2'b00, 0, 4};
    tbl[5]  = '{2'b00, 1, 4, 2'b00, 0, 0,   2'b01, 3, 3};
    tbl[6]  = '{2'b00, 1, 5, 2'b00, 0, 0,   2'b10, 4, 2};
    tbl[7]  = '{2'b00, 1, 6, 2'b00, 0, 0,   2'b01, 5, 1};
    tbl[8]  = '{2'b00, 0, 0, 2'b00, 0, 0,   2'b10, 6, 0};
    tbl[9]  = '{2'b01, 0, 0, 2'b01, 0, 0,   2'b00, 0, 0};
    tbl[10] = '{2'b00, 0, 0, 2'b00, 1, 25,  2'b00, 0, 1};
    tbl[11] = '{2'b00, 0, 0, 2'b00, 0, 0,   2'b00, 0, 1};
    tbl[12] = '{2'b00, 0, 0, 2'b00, 0, 0,   2'b00, 0, 1};
    tbl[13] = '{2'b00, 1, 5, 2'b00, 0, 0,   2'b00, 0, 1};
    tbl[14] = '{2'b00, 0, 0, 2'b00, 0, 0,   2'b01, 5, 0};
    tbl[15] = '{2'b00, 0, 0, 2'b00, 0, 0,   2'b00, 0, 0};
    nxt();
    #1;
    chk("rst_inflight", inflight, 0);
    chk("rst_in_valid", sqrt_in_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err", err_underflow, 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].rv;
      sqrt_out_valid = tbl[i].ov;
      sqrt_out_data = tbl[i].od;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_in_valid", i), sqrt_in_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) chk($sformatf("v%0d_in_data", i), sqrt_in_data, tbl[i].e_id);
      chk($sformatf("v%0d_resp_valid", i), resp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv != 0) chk($sformatf("v%0d_resp_data", i), resp_data, tbl[i].e_rd);
      chk($sformatf("v%0d_inflight", i), inflight, tbl[i].e_inf);
      chk($sformatf("v%0d_drained", i), drained, 0);
      chk($sformatf("v%0d_err", i), err_underflow, 0);
      nxt();
    end
    // T3: core stalled, continuous requests fill the tag FIFO
    req_valid = 2'b11;
    sqrt_out_valid = 1'b0;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready != 0) grants++;
      nxt();
    end
    #1;
    chk("t3_grants", grants, 8);
    chk("t3_ready_full", req_ready, 2'b00);
    chk("t3_inflight_full", inflight, 8);
    sqrt_out_valid = 1'b1;
    sqrt_out_data = 24'd1;
    nxt();
    sqrt_out_valid = 1'b0;
    #1;
    chk("t3_inflight_after_pop", inflight, 7);
    chk("t3_regrant", req_ready, 2'b10);
    nxt();
    #1;
    chk("t3_ready_refull", req_ready, 2'b00);
    chk("t3_inflight_refull", inflight, 8);
    req_valid = 2'b00;
    sqrt_out_valid = 1'b1;
    repeat (3) nxt();
    sqrt_out_valid = 1'b0;
    #1;
    chk("t6_pre_inflight", inflight, 5);
    // T6: asynchronous reset mid-cycle with 5 in flight
    req_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_inflight", inflight, 0);
    chk("t6_ready", req_ready, 2'b00);
    chk("t6_in_valid", sqrt_in_valid, 0);
    chk("t6_resp_valid", resp_valid, 0);
    nxt();
    rst_n = 1'b1;
    #1;
    chk("t6_first_grant", req_ready, 2'b01);
    // T4: 3 in flight, flush, drain, resume
    nxt();
    #1;
    chk("t4_grant1", req_ready, 2'b10);
    nxt();
    #1;
    chk("t4_grant2", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    flush = 1'b1;
    #1;
    chk("t4_inflight3", inflight, 3);
    chk("t4_drained_early", drained, 0);
    nxt();
    flush = 1'b0;
    req_valid = 2'b11;
    sqrt_out_valid = 1'b1;
    sqrt_out_data = 24'd7;
    #1;
    chk("t4_no_grant", req_ready, 2'b00);
    nxt();
    sqrt_out_data = 24'd8;
    #1;
    chk("t4_resp0", {resp_valid, resp_data}, {2'b01, 24'd7});
    chk("t4_inflight2", inflight, 2);
    chk("t4_no_grant2", req_ready, 2'b00);
    nxt();
    sqrt_out_data = 24'd9;
    #1;
    chk("t4_resp1", {resp_valid, resp_data}, {2'b10, 24'd8});
    chk("t4_drained_mid", drained, 0);
    nxt();
    sqrt_out_valid = 1'b0;
    #1;
    chk("t4_resp2", {resp_valid, resp_data}, {2'b01, 24'd9});
    chk("t4_inflight0", inflight, 0);
    chk("t4_drained", drained, 1);
    chk("t4_no_grant3", req_ready, 2'b00);
    nxt();
    #1;
    chk("t4_drained_pulse", drained, 0);
    chk("t4_resume", req_ready, 2'b10);
    req_valid = 2'b00;
    // T5: result with nothing in flight
    nxt();
    sqrt_out_valid = 1'b1;
    sqrt_out_data = 24'd11;
    #1;
    chk("t5_err_before", err_underflow, 0);
    nxt();
    sqrt_out_valid = 1'b0;
    #1;
    chk("t5_no_resp", resp_valid, 2'b00);
    chk("t5_err", err_underflow, 1);
    chk("t5_inflight", inflight, 0);
    repeat (3) nxt();
    #1;
    chk("t5_err_sticky", err_underflow, 1);
    // flush with nothing in flight: one DRAIN cycle pulses drained
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("fe_drained", drained, 1);
    chk("fe_no_grant", req_ready, 2'b00);
    nxt();
    #1;
    chk("fe_drained_pulse", drained, 0);
    chk("fe_resume", req_ready, 2'b10);
    req_valid = 2'b00;
    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
